alu_arbiter: RTL



---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_arbiter_if.sv | 51 +++++
 rtl/alu.sv | 61 ++++++
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared widths, ALU operation encodings and request bundle for the
// ALU arbiter slice.
package alu_pkg;

    localparam int DW = 32;
    localparam int CW = 14;
    localparam int RW = 5;

    // Number of operations the ALU implements; one control bit per operation.
    localparam int ALU_NOPS = 14;

    // One-hot control encodings (bit position == operation index).
    localparam logic [CW-1:0] ALU_ADD  = 14'h0001;
    localparam logic [CW-1:0] ALU_SUB  = 14'h0002;
    localparam logic [CW-1:0] ALU_AND  = 14'h0004;
    localparam logic [CW-1:0] ALU_OR   = 14'h0008;
    localparam logic [CW-1:0] ALU_XOR  = 14'h0010;
    localparam logic [CW-1:0] ALU_NOR  = 14'h0020;
    localparam logic [CW-1:0] ALU_SLL  = 14'h0040;
    localparam logic [CW-1:0] ALU_SRL  = 14'h0080;
    localparam logic [CW-1:0] ALU_SRA  = 14'h0100;
    localparam logic [CW-1:0] ALU_SLT  = 14'h0200;
    localparam logic [CW-1:0] ALU_SLTU = 14'h0400;
    localparam logic [CW-1:0] ALU_LUI  = 14'h0800;
    localparam logic [CW-1:0] ALU_ANDN = 14'h1000;
    localparam logic [CW-1:0] ALU_MOV  = 14'h2000;

    // One operation as presented by a requester.
    typedef struct packed {
        logic [DW-1:0] src1;
        logic [DW-1:0] src2;
        logic [CW-1:0] control;
        logic [RW-1:0] wd;
        logic          wreg;
    } req_t;

    // Output buffer occupancy.
    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // True when exactly one control bit is set.
    function automatic logic is_onehot(logic [CW-1:0] c);
        return (c != '0) && ((c & (c - CW'(1))) == '0);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two execute-stage requesters,
// the arbiter and the writeback consumer.
interface alu_arbiter_if #(
    parameter int DW = alu_pkg::DW,
    parameter int CW = alu_pkg::CW,
    parameter int RW = alu_pkg::RW
);
    logic          a_valid;
    logic          a_ready;
    logic [DW-1:0] a_src1;
    logic [DW-1:0] a_src2;
    logic [CW-1:0] a_control;
    logic [RW-1:0] a_wd;
    logic          a_wreg;

    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] b_src1;
    logic [DW-1:0] b_src2;
    logic [CW-1:0] b_control;
    logic [RW-1:0] b_wd;
    logic          b_wreg;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic [RW-1:0] out_wd;
    logic          out_wreg;
    logic          out_id;
    logic          out_err;

    // Requesters and writeback side.
    modport master (
        output a_valid, a_src1, a_src2, a_control, a_wd, a_wreg,
        input  a_ready,
        output b_valid, b_src1, b_src2, b_control, b_wd, b_wreg,
        input  b_ready,
        input  out_valid, out_result, out_wd, out_wreg, out_id, out_err,
        output out_ready
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_src1, a_src2, a_control, a_wd, a_wreg,
        output a_ready,
        input  b_valid, b_src1, b_src2, b_control, b_wd, b_wreg,
        output b_ready,
        output out_valid, out_result, out_wd, out_wreg, out_id, out_err,
        input  out_ready
    );
endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU with one-hot operation select.
// Every selected operation contributes to the result through an AND-OR
// mux, so a zero control gives 0 and a multi-hot control gives the OR
// of the selected operation results. wd/wreg pass straight through.
module alu
    import alu_pkg::*;
#(
    parameter int DW = alu_pkg::DW,
    parameter int CW = alu_pkg::CW,
    parameter int RW = alu_pkg::RW
) (
    input  logic [DW-1:0] src1_i,
    input  logic [DW-1:0] src2_i,
    input  logic [CW-1:0] control_i,
    input  logic [RW-1:0] wd_i,
    input  logic          wreg_i,
    output logic [DW-1:0] result_o,
    output logic [RW-1:0] wd_o,
    output logic          wreg_o
);

    logic [4:0]    shamt;
    logic [DW-1:0] op_res [ALU_NOPS];
    logic [DW-1:0] masked [ALU_NOPS];

    assign shamt = src2_i[4:0];

    assign op_res[0]  = src1_i + src2_i;
    assign op_res[1]  = src1_i - src2_i;
    assign op_res[2]  = src1_i & src2_i;
    assign op_res[3]  = src1_i | src2_i;
    assign op_res[4]  = src1_i ^ src2_i;
    assign op_res[5]  = ~(src1_i | src2_i);
    assign op_res[6]  = src1_i << shamt;
    assign op_res[7]  = src1_i >> shamt;
    assign op_res[8]  = $signed(src1_i) >>> shamt;
    assign op_res[9]  = {{(DW-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
    assign op_res[10] = {{(DW-1){1'b0}}, (src1_i < src2_i)};
    assign op_res[11] = src2_i << 16;
    assign op_res[12] = src1_i & ~src2_i;
    assign op_res[13] = src2_i;

    // Gate each operation result with its control bit.
    generate
        for (genvar gi = 0; gi < ALU_NOPS; gi++) begin : g_mask
            assign masked[gi] = control_i[gi] ? op_res[gi] : '0;
        end
    endgenerate

    // OR together the gated results.
    always_comb begin
        result_o = '0;
        for (int i = 0; i < ALU_NOPS; i++) begin
            result_o = result_o | masked[i];
        end
    end

    assign wd_o   = wd_i;
    assign wreg_o = wreg_i;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between requesters A and B, with a
// one-entry output buffer toward writeback. Readies depend only on the
// valids, buffer state, out_ready and the priority pointer.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DW = alu_pkg::DW,
    parameter int CW = alu_pkg::CW,
    parameter int RW = alu_pkg::RW
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    buf_state_t    state_q, state_d;
    logic          rr_q, rr_d;
    logic [DW-1:0] result_q, result_d;
    logic [RW-1:0] wd_q, wd_d;
    logic          wreg_q, wreg_d;
    logic          id_q, id_d;
    logic          err_q, err_d;

    logic          can_accept;
    logic          grant_a;
    logic          grant_b;
    logic          grant;

    logic [DW-1:0] sel_src1;
    logic [DW-1:0] sel_src2;
    logic [CW-1:0] sel_control;
    logic [RW-1:0] sel_wd;
    logic          sel_wreg;

    logic [DW-1:0] alu_result;
    logic [RW-1:0] alu_wd;
    logic          alu_wreg;

    // Arbitration: a grant needs buffer space; ties go to the rr pointer.
    // Readies are held low while reset is asserted.
    always_comb begin
        can_accept = (state_q == BUF_EMPTY) || bus.out_ready;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        if (!rst && can_accept) begin
            if (bus.a_valid && (!bus.b_valid || !rr_q)) begin
                grant_a = 1'b1;
            end else if (bus.b_valid) begin
                grant_b = 1'b1;
            end
        end
        grant = grant_a || grant_b;
    end

    // Operand mux: steer the winner's fields into the shared ALU.
    always_comb begin
        sel_src1    = bus.a_src1;
        sel_src2    = bus.a_src2;
        sel_control = bus.a_control;
        sel_wd      = bus.a_wd;
        sel_wreg    = bus.a_wreg;
        if (grant_b) begin
            sel_src1    = bus.b_src1;
            sel_src2    = bus.b_src2;
            sel_control = bus.b_control;
            sel_wd      = bus.b_wd;
            sel_wreg    = bus.b_wreg;
        end
    end

    alu #(
        .DW (DW),
        .CW (CW),
        .RW (RW)
    ) u_alu (
        .src1_i    (sel_src1),
        .src2_i    (sel_src2),
        .control_i (sel_control),
        .wd_i      (sel_wd),
        .wreg_i    (sel_wreg),
        .result_o  (alu_result),
        .wd_o      (alu_wd),
        .wreg_o    (alu_wreg)
    );

    // Buffer state, pointer and payload next-state; a grant while FULL
    // with out_ready replaces the entry on the same edge.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        result_d = result_q;
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        id_d     = id_q;
        err_d    = err_q;

        case (state_q)
            BUF_EMPTY: if (grant)              state_d = BUF_FULL;
            BUF_FULL:  if (!grant && bus.out_ready) state_d = BUF_EMPTY;
            default:                           state_d = BUF_EMPTY;
        endcase

        if (grant) begin
            // Loser gets priority next time.
            rr_d     = grant_a;
            result_d = alu_result;
            wd_d     = alu_wd;
            wreg_d   = alu_wreg;
            id_d     = grant_b;
            err_d    = !is_onehot(sel_control);
        end
    end

    // State and buffer registers; reset discards any buffered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BUF_EMPTY;
            rr_q     <= 1'b0;
            result_q <= '0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            result_q <= result_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            id_q     <= id_d;
            err_q    <= err_d;
        end
    end

    assign bus.a_ready    = grant_a;
    assign bus.b_ready    = grant_b;
    assign bus.out_valid  = (state_q == BUF_FULL);
    assign bus.out_result = result_q;
    assign bus.out_wd     = wd_q;
    assign bus.out_wreg   = wreg_q;
    assign bus.out_id     = id_q;
    assign bus.out_err    = err_q;

endmodule
